rect_plotter: RTL and testbench
===============================

// Module: rect_plotter
// PURPOSE
//  Rectangle pixel-scan engine between the game-control FSMs (paddle, ball, bricks) and vga_adapter.
//  Accepts one rectangle request per valid/ready handshake and emits its pixels, one per clock.
//  Each pixel is presented as x/y/colour/plot on the 160x120 frame buffer port.
//  Erasing is a request whose colour is the background colour.
// PARAMETERS
//  XW       8    x coordinate width (bits)
//  YW       7    y coordinate width (bits)
//  CW       3    colour width (bits)
//  XSCREEN  160  visible width in pixels; used only when clipping is compiled in
//  YSCREEN  120  visible height in pixels; used only when clipping is compiled in
// PORTS
//  CLOCK_50   in   1    system clock, 50 MHz
//  Resetn     in   1    synchronous, active-low reset
//  req_valid  in   1    request present
//  req_ready  out  1    engine can accept a request (high in IDLE only)
//  req_x      in   XW   top-left x of the rectangle
//  req_y      in   YW   top-left y of the rectangle
//  req_w      in   XW   width in pixels (0 = empty rectangle)
//  req_h      in   YW   height in pixels (0 = empty rectangle)
//  req_colour in   CW   fill colour
//  VGA_X      out  XW   pixel x to vga_adapter
//  VGA_Y      out  YW   pixel y to vga_adapter
//  VGA_COLOR  out  CW   pixel colour to vga_adapter
//  plot       out  1    write strobe to vga_adapter
//  busy       out  1    high in DRAW and DONE
//  done       out  1    one-cycle pulse when a request completes
// BEHAVIOUR
//  - Reset values: state=IDLE, xc=0, yc=0, plot=0, done=0, busy=0, req_ready=1; VGA_X/VGA_Y/VGA_COLOR=0.
//  - States and transitions:
//    - IDLE: req_ready=1. On req_valid&&req_ready, latch x,y,w,h,colour and clear xc and yc.
//      If w==0 or h==0 go to DONE; otherwise go to DRAW.
//    - DRAW: plot=1 every cycle.
//      - VGA_X = x_q + xc, truncated to XW bits, wraps.
//      - VGA_Y = y_q + yc, truncated to YW bits, wraps.
//      - VGA_COLOR = colour_q.
//      - xc increments each cycle. When xc==w_q-1: xc<=0 and yc increments.
//      - When xc==w_q-1 and yc==h_q-1 this is the last pixel; go to DONE.
//    - DONE: done=1 for exactly one cycle, plot=0, then return to IDLE.
//  - Pixel order is raster: x fastest, then y.
//  - Latency:
//    - First plot appears the cycle after acceptance.
//    - A w*h rectangle occupies exactly w*h DRAW cycles plus 1 DONE cycle.
//    - A new request can be accepted the cycle after DONE.
//  - Request inputs are ignored outside IDLE; no queueing; req_valid held during busy has no effect.
//  - Counter widths: xc is XW bits and yc is YW bits; w=2^XW-1 is legal.
//  - Outside DRAW: plot=0 and VGA_X/VGA_Y/VGA_COLOR hold their last values.
//  - Reset mid-operation: on the next edge the engine is in IDLE with plot=0 and no done pulse.
//    Any partial rectangle remains in the frame buffer.
// CONFIGURATION
//  - RECT_PLOTTER_CLIP_EN defined:
//    - plot=0 for any pixel where (x_q+xc) >= XSCREEN or (y_q+yc) >= YSCREEN.
//    - Sums are computed one bit wider, so there is no wrap.
//    - The cycle is still consumed, so latency is unchanged.
//  - RECT_PLOTTER_CLIP_EN undefined: coordinates wrap modulo 2^XW / 2^YW and every DRAW cycle plots.
// STRUCTURE
//  - Shared package/header game_defs:
//    - XSCREEN, YSCREEN, XW, YW, CW
//    - colour constants: BLACK=3'b000, WHITE=3'b111
//    - state encodings: IDLE, DRAW, DONE
//  - Sub-module scan_counter: 2-D xc/yc counter.
//    - Inputs: clr, en, w, h.
//    - Outputs: xc, yc, last.
//  - FSM and output muxing stay in rect_plotter.
// TESTING
//  1. Reset, then request x=10 y=20 w=3 h=2 colour=3'b100.
//     -> 6 plots: (10,20)(11,20)(12,20)(10,21)(11,21)(12,21);
//        then done one cycle later; req_ready returns 1.
//  2. Request with w=0, h=5 -> no plot; done is asserted the cycle after acceptance.
//  3. Request x=158 y=119 w=4 h=2:
//     -> clip off: 8 plots, x wraps 158,159,160,161 and y 119,120;
//     -> clip on: only (158,119) and (159,119) plot; done is still at cycle 9.
//  4. Hold req_valid high with changing fields during DRAW.
//     -> no second acceptance until IDLE; the output pixels match the first request only.
//  5. Assert Resetn=0 during pixel 3 of a 20x1 request.
//     -> the next cycle has plot=0, busy=0, req_ready=1 and no done pulse.
//  6. Back-to-back requests: 20x1 at (39,100) colour 3'b111, then the same rectangle with colour 3'b000.
//     -> 20 white plots, done, idle cycle, 20 black plots at identical x/y.

Source files
------------

// File: rtl/rect_plotter_pkg.sv
// Shared game definitions for the rectangle plotter: screen geometry, field widths,
// colour constants and the plotter state encoding.
package rect_plotter_pkg;

  localparam int XW      = 8;
  localparam int YW      = 7;
  localparam int CW      = 3;
  localparam int XSCREEN = 160;
  localparam int YSCREEN = 120;

  localparam logic [CW-1:0] BLACK = 3'b000;
  localparam logic [CW-1:0] WHITE = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/rect_plotter_if.sv
// Rectangle request channel: one valid/ready handshake per rectangle.
interface rect_plotter_if;
  import rect_plotter_pkg::*;

  logic          req_valid;
  logic          req_ready;
  logic [XW-1:0] req_x;
  logic [YW-1:0] req_y;
  logic [XW-1:0] req_w;
  logic [YW-1:0] req_h;
  logic [CW-1:0] req_colour;

  modport master (
    output req_valid, req_x, req_y, req_w, req_h, req_colour,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_x, req_y, req_w, req_h, req_colour,
    output req_ready
  );

endinterface

// File: rtl/rect_plotter_scan_counter.sv
// Two-dimensional raster counter: xc runs fastest across w columns, then yc advances.
module scan_counter
  import rect_plotter_pkg::*;
(
  input  logic          CLOCK_50,
  input  logic          Resetn,
  input  logic          clr,
  input  logic          en,
  input  logic [XW-1:0] w,
  input  logic [YW-1:0] h,
  output logic [XW-1:0] xc,
  output logic [YW-1:0] yc,
  output logic          last
);

  logic row_end;

  assign row_end = (xc == w - XW'(1));
  assign last    = row_end && (yc == h - YW'(1));

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      xc <= '0;
      yc <= '0;
    end else if (clr) begin
      xc <= '0;
      yc <= '0;
    end else if (en) begin
      if (row_end) begin
        xc <= '0;
        yc <= yc + YW'(1);
      end else begin
        xc <= xc + XW'(1);
      end
    end
  end

endmodule

// File: rtl/rect_plotter.sv
// Rectangle pixel-scan engine feeding vga_adapter, one pixel per clock in raster order.
// Optional screen-edge clipping is compiled in with RECT_PLOTTER_CLIP_EN.
module rect_plotter
  import rect_plotter_pkg::*;
(
  input  logic          CLOCK_50,
  input  logic          Resetn,
  rect_plotter_if.slave req,
  output logic [XW-1:0] VGA_X,
  output logic [YW-1:0] VGA_Y,
  output logic [CW-1:0] VGA_COLOR,
  output logic          plot,
  output logic          busy,
  output logic          done
);

  state_t        state, state_next;
  logic [XW-1:0] x_q, w_q, xc, vga_x_q, pix_x;
  logic [YW-1:0] y_q, h_q, yc, vga_y_q, pix_y;
  logic [CW-1:0] colour_q, vga_c_q;
  logic          accept, drawing, last, in_view;

  assign accept  = (state == IDLE) && req.req_valid;
  assign drawing = (state == DRAW);
  assign pix_x   = x_q + xc;
  assign pix_y   = y_q + yc;

  scan_counter u_scan (
    .CLOCK_50 (CLOCK_50),
    .Resetn   (Resetn),
    .clr      (accept),
    .en       (drawing),
    .w        (w_q),
    .h        (h_q),
    .xc       (xc),
    .yc       (yc),
    .last     (last)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      x_q      <= '0;
      y_q      <= '0;
      w_q      <= '0;
      h_q      <= '0;
      colour_q <= '0;
    end else if (accept) begin
      x_q      <= req.req_x;
      y_q      <= req.req_y;
      w_q      <= req.req_w;
      h_q      <= req.req_h;
      colour_q <= req.req_colour;
    end
  end

  // Remember the last driven pixel so the VGA bus holds steady outside DRAW.
  always_ff @(posedge CLOCK_50) begin
    if (!Resetn) begin
      vga_x_q <= '0;
      vga_y_q <= '0;
      vga_c_q <= '0;
    end else if (drawing) begin
      vga_x_q <= pix_x;
      vga_y_q <= pix_y;
      vga_c_q <= colour_q;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept)
              state_next = ((req.req_w == '0) || (req.req_h == '0)) ? DONE : DRAW;
      DRAW: if (last) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef RECT_PLOTTER_CLIP_EN
  logic [XW:0] x_sum;
  logic [YW:0] y_sum;
  assign x_sum   = {1'b0, x_q} + {1'b0, xc};
  assign y_sum   = {1'b0, y_q} + {1'b0, yc};
  assign in_view = (x_sum < (XW+1)'(XSCREEN)) && (y_sum < (YW+1)'(YSCREEN));
`else
  assign in_view = 1'b1;
`endif

  assign req.req_ready = (state == IDLE);
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign plot          = drawing && in_view;
  assign VGA_X         = drawing ? pix_x    : vga_x_q;
  assign VGA_Y         = drawing ? pix_y    : vga_y_q;
  assign VGA_COLOR     = drawing ? colour_q : vga_c_q;

endmodule

// File: tb/tb_rect_plotter.sv
// Scoreboard bench for rect_plotter: requests expand into timestamped expected pixels.
module tb_rect_plotter;
  import rect_plotter_pkg::*;

  logic          CLOCK_50 = 1'b0;
  logic          Resetn   = 1'b0;
  logic [XW-1:0] VGA_X;
  logic [YW-1:0] VGA_Y;
  logic [CW-1:0] VGA_COLOR;
  logic          plot, busy, done;

  rect_plotter_if rif ();

  rect_plotter dut (
    .CLOCK_50  (CLOCK_50),
    .Resetn    (Resetn),
    .req       (rif),
    .VGA_X     (VGA_X),
    .VGA_Y     (VGA_Y),
    .VGA_COLOR (VGA_COLOR),
    .plot      (plot),
    .busy      (busy),
    .done      (done)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  typedef struct {
    int x;
    int y;
    int c;
    int t;
  } pix_t;

  pix_t pix_q[$];
  int   done_q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Reference model: every pixel of the rectangle in raster order with the cycle it must appear.
  task automatic pushModel(input int x, input int y, input int w, input int h, input int c, input int acc);
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx++) begin
        pix_t p;
        bit   show;
        show = 1'b1;
`ifdef RECT_PLOTTER_CLIP_EN
        if ((x + xx) >= XSCREEN || (y + yy) >= YSCREEN) show = 1'b0;
`endif
        p.x = (x + xx) % (1 << XW);
        p.y = (y + yy) % (1 << YW);
        p.c = c;
        p.t = acc + yy * w + xx;
        if (show) pix_q.push_back(p);
      end
    end
    done_q.push_back(acc + w * h);
  endtask

  task automatic applyStimulus(input int x, input int y, input int w, input int h, input int c,
                               input bit hold, output int acc);
    int n;
    n = 0;
    while (!rif.req_ready && n < 300) begin
      @(posedge CLOCK_50); #1;
      n++;
    end
    if (!rif.req_ready) checkOutput("ready_wait", 32'(rif.req_ready), 32'd1);
    rif.req_valid  = 1'b1;
    rif.req_x      = XW'(x);
    rif.req_y      = YW'(y);
    rif.req_w      = XW'(w);
    rif.req_h      = YW'(h);
    rif.req_colour = CW'(c);
    @(posedge CLOCK_50); #1;
    acc = cyc;
    pushModel(x, y, w, h, c, acc);
    if (hold) begin
      n = 0;
      while (!done && n < 40000) begin
        rif.req_x      = XW'($urandom);
        rif.req_y      = YW'($urandom);
        rif.req_w      = XW'($urandom);
        rif.req_h      = YW'($urandom);
        rif.req_colour = CW'($urandom);
        @(posedge CLOCK_50); #1;
        n++;
      end
    end
    rif.req_valid = 1'b0;
  endtask

  task automatic waitReady(input int acc, input int npix);
    int n;
    n = 0;
    while (!rif.req_ready && n < 40000) begin
      @(posedge CLOCK_50); #1;
      n++;
    end
    checkOutput("ready_return", 32'(cyc), 32'(acc + npix + 1));
  endtask

  // Monitor: pops expected pixels and done pulses, flagging anything missing, late or extra.
  always @(negedge CLOCK_50) begin
    while (pix_q.size() > 0 && pix_q[0].t < cyc) begin
      void'(pix_q.pop_front());
      checkOutput("missed_pixel", 32'(plot), 32'd1);
    end
    while (done_q.size() > 0 && done_q[0] < cyc) begin
      void'(done_q.pop_front());
      checkOutput("missed_done", 32'(done), 32'd1);
    end
    if (plot) begin
      if (pix_q.size() == 0) begin
        checkOutput("unexpected_plot", 32'(plot), 32'd0);
      end else begin
        pix_t        p;
        logic [17:0] want;
        p    = pix_q.pop_front();
        want = {8'(p.x), 7'(p.y), 3'(p.c)};
        checkOutput("pixel_xyc", 32'({VGA_X, VGA_Y, VGA_COLOR}), 32'(want));
        checkOutput("pixel_time", 32'(cyc), 32'(p.t));
      end
    end
    if (done) begin
      if (done_q.size() == 0) checkOutput("unexpected_done", 32'(done), 32'd0);
      else checkOutput("done_time", 32'(cyc), 32'(done_q.pop_front()));
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int acc;
    rif.req_valid  = 1'b0;
    rif.req_x      = '0;
    rif.req_y      = '0;
    rif.req_w      = '0;
    rif.req_h      = '0;
    rif.req_colour = '0;
    repeat (2) @(posedge CLOCK_50);
    #1;
    checkOutput("rst_ready", 32'(rif.req_ready), 32'd1);
    checkOutput("rst_plot", 32'(plot), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_vga", 32'({VGA_X, VGA_Y, VGA_COLOR}), 32'd0);
    Resetn = 1'b1;
    @(posedge CLOCK_50); #1;

    $display("[TB] basic 3x2 rectangle");
    applyStimulus(10, 20, 3, 2, 3'b100, 1'b0, acc);
    waitReady(acc, 6);

    $display("[TB] empty rectangle");
    applyStimulus(7, 9, 0, 5, 3'b010, 1'b0, acc);
    checkOutput("empty_done", 32'({done, plot}), 32'b10);
    waitReady(acc, 0);

    $display("[TB] edge rectangle");
    applyStimulus(158, 119, 4, 2, 3'b101, 1'b0, acc);
    waitReady(acc, 8);

    $display("[TB] request held during draw");
    applyStimulus(30, 40, 5, 3, 3'b011, 1'b1, acc);
    waitReady(acc, 15);
    @(posedge CLOCK_50); #1;
    checkOutput("hold_no_accept", 32'(busy), 32'd0);

    $display("[TB] reset mid-rectangle");
    applyStimulus(5, 5, 20, 1, 3'b110, 1'b0, acc);
    repeat (2) begin
      @(posedge CLOCK_50); #1;
    end
    Resetn = 1'b0;
    @(posedge CLOCK_50); #1;
    checkOutput("midrst_state", 32'({plot, busy, rif.req_ready, done}), 32'b0010);
    pix_q.delete();
    done_q.delete();
    Resetn = 1'b1;
    @(posedge CLOCK_50); #1;

    $display("[TB] back-to-back white then black");
    applyStimulus(39, 100, 20, 1, WHITE, 1'b0, acc);
    waitReady(acc, 20);
    applyStimulus(39, 100, 20, 1, BLACK, 1'b0, acc);
    waitReady(acc, 20);

    $display("[TB] randomized requests");
    for (int i = 0; i < 30; i++) begin
      int rx, ry, rw, rh, rc;
      bit rhold;
      rx    = $urandom_range(255, 0);
      ry    = $urandom_range(127, 0);
      rw    = $urandom_range(12, 0);
      rh    = $urandom_range(6, 0);
      rc    = $urandom_range(7, 0);
      rhold = (rw != 0) && (rh != 0) && ($urandom_range(3, 0) == 0);
      applyStimulus(rx, ry, rw, rh, rc, rhold, acc);
      waitReady(acc, rw * rh);
    end

    repeat (4) @(posedge CLOCK_50);
    #1;
    checkOutput("leftover", 32'(pix_q.size() + done_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
